meter_channel_scheduler: RTL and testbench

//   Time-shares one duration_meter (period/duty measurement engine) across N_CH GPIO inputs.

---
 rtl/meter_channel_scheduler_pkg.sv | 36 +++
 rtl/meter_channel_scheduler_if.sv | 34 +++
 rtl/meter_channel_scheduler_rr_pick.sv | 53 +++++
 rtl/meter_channel_scheduler.sv | 138 +++++++++++++
 tb/tb_meter_channel_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/meter_channel_scheduler_pkg.sv
// Shared types, constants and helpers for the meter channel scheduler.
package meter_channel_scheduler_pkg;

  localparam int N_CH      = 4;
  localparam int CH_W      = 2;
  localparam int CLEAR_LEN = 2;
  localparam int SETTLE    = 4;

  localparam logic [31:0]     DWELL_MIN   = 32'd16;
  localparam logic [31:0]     NOSIG_HI    = 32'hFFFF_FFFF;
  localparam logic [31:0]     NOSIG_LO    = 32'h0000_0000;
  // Down-counter reload values: a phase of L cycles counts L-1 .. 0
  localparam logic [31:0]     CLEAR_LOAD  = 32'(CLEAR_LEN - 1);
  localparam logic [31:0]     SETTLE_LOAD = 32'(SETTLE - 1);
  // Highest channel index: picking "above" it yields the lowest set bit
  localparam logic [CH_W-1:0] CH_TOP      = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_DWELL   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_e;

  // Measurement window length with the lower clamp applied
  function automatic logic [31:0] clamp_dwell(input logic [31:0] d);
    return (d < DWELL_MIN) ? DWELL_MIN : d;
  endfunction

  // A stuck-low or saturated period means no toggling input was seen
  function automatic logic is_nosignal(input logic [31:0] p);
    return (p == NOSIG_LO) || (p == NOSIG_HI);
  endfunction

endpackage

// File: rtl/meter_channel_scheduler_if.sv
// Control, meter and result signals of the meter channel scheduler.
// master = scheduler side, slave = surrounding logic (mux, meter, consumer).
interface meter_channel_scheduler_if;
  import meter_channel_scheduler_pkg::*;

  logic            enable;
  logic            single_shot;
  logic [N_CH-1:0] chan_mask;
  logic [31:0]     dwell_cycles;
  logic [31:0]     meter_period;
  logic [31:0]     meter_duty;
  logic [CH_W-1:0] meter_sel;
  logic            meter_clear;
  logic            res_valid;
  logic [CH_W-1:0] res_chan;
  logic [31:0]     res_period;
  logic [31:0]     res_duty;
  logic            res_nosignal;
  logic            busy;
  logic            pass_done;

  modport master (
    input  enable, single_shot, chan_mask, dwell_cycles, meter_period, meter_duty,
    output meter_sel, meter_clear, res_valid, res_chan, res_period, res_duty,
           res_nosignal, busy, pass_done
  );

  modport slave (
    output enable, single_shot, chan_mask, dwell_cycles, meter_period, meter_duty,
    input  meter_sel, meter_clear, res_valid, res_chan, res_period, res_duty,
           res_nosignal, busy, pass_done
  );

endinterface

// File: rtl/meter_channel_scheduler_rr_pick.sv
// meter_rr_pick: combinational round-robin picker. Returns the first set
// mask bit strictly above cur; if none, the lowest set bit with wrapped=1.
// none=1 when the mask is empty.
module meter_rr_pick
  import meter_channel_scheduler_pkg::*;
(
  input  logic [N_CH-1:0] mask,
  input  logic [CH_W-1:0] cur,
  output logic [CH_W-1:0] next_ch,
  output logic            wrapped,
  output logic            none
);

  logic [CH_W-1:0] above_s;
  logic [CH_W-1:0] lowest_s;
  logic            has_above_s;
  logic            has_any_s;

  // Descending scan: the last hit is the lowest qualifying index
  always_comb begin
    above_s     = {CH_W{1'b0}};
    lowest_s    = {CH_W{1'b0}};
    has_above_s = 1'b0;
    has_any_s   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_s  = CH_W'(i);
        has_any_s = 1'b1;
        if (i > int'(cur)) begin
          above_s     = CH_W'(i);
          has_above_s = 1'b1;
        end else begin
          has_above_s = has_above_s;
        end
      end else begin
        has_any_s = has_any_s;
      end
    end
  end

  // Select between the upward hit and the wrap-around candidate
  always_comb begin
    if (has_above_s) begin
      next_ch = above_s;
      wrapped = 1'b0;
    end else begin
      next_ch = lowest_s;
      wrapped = has_any_s;
    end
    none = ~has_any_s;
  end

endmodule

// File: rtl/meter_channel_scheduler.sv
// meter_channel_scheduler: time-shares one duration meter across N_CH inputs.
// Per channel: route input, clear meter, settle, dwell, capture result.
module meter_channel_scheduler
  import meter_channel_scheduler_pkg::*;
(
  input logic                        clock,
  input logic                        reset_n,
  meter_channel_scheduler_if.master  bus
);

  state_e          state_r;
  logic [31:0]     cnt_r;
  logic [CH_W-1:0] next_ch_r;
  logic            stop_r;
  logic            disarm_r;
  logic            armed_r;

  logic [CH_W-1:0] cur_s;
  logic [CH_W-1:0] rr_next_s;
  logic            rr_wrapped_s;
  logic            rr_none_s;

  // In IDLE search from the top so the picker returns the lowest set bit
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_s = CH_TOP;
    end else begin
      cur_s = bus.meter_sel;
    end
  end

  meter_rr_pick u_rr_pick (
    .mask    (bus.chan_mask),
    .cur     (cur_s),
    .next_ch (rr_next_s),
    .wrapped (rr_wrapped_s),
    .none    (rr_none_s)
  );

  // Scheduler FSM, shared phase down-counter and registered outputs.
  // The next-channel pick is taken on the DWELL->CAPTURE edge so that
  // pass_done can be a registered pulse aligned with res_valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      cnt_r            <= 32'd0;
      next_ch_r        <= {CH_W{1'b0}};
      stop_r           <= 1'b0;
      disarm_r         <= 1'b0;
      armed_r          <= 1'b1;
      bus.meter_sel    <= {CH_W{1'b0}};
      bus.meter_clear  <= 1'b0;
      bus.res_valid    <= 1'b0;
      bus.res_chan     <= {CH_W{1'b0}};
      bus.res_period   <= 32'd0;
      bus.res_duty     <= 32'd0;
      bus.res_nosignal <= 1'b0;
      bus.busy         <= 1'b0;
      bus.pass_done    <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      bus.pass_done <= 1'b0;
      if (!bus.enable) begin
        // Abort anywhere; results stay held, a single-shot run is re-armed
        state_r         <= ST_IDLE;
        cnt_r           <= 32'd0;
        armed_r         <= 1'b1;
        bus.meter_clear <= 1'b0;
        bus.busy        <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (armed_r && !rr_none_s) begin
              state_r         <= ST_CLEAR;
              cnt_r           <= CLEAR_LOAD;
              bus.meter_sel   <= rr_next_s;
              bus.meter_clear <= 1'b1;
              bus.busy        <= 1'b1;
            end
          end
          ST_CLEAR: begin
            if (cnt_r == 32'd0) begin
              state_r         <= ST_SETTLE;
              cnt_r           <= SETTLE_LOAD;
              bus.meter_clear <= 1'b0;
            end else begin
              cnt_r <= cnt_r - 32'd1;
            end
          end
          ST_SETTLE: begin
            if (cnt_r == 32'd0) begin
              state_r <= ST_DWELL;
              cnt_r   <= clamp_dwell(bus.dwell_cycles) - 32'd1;
            end else begin
              cnt_r <= cnt_r - 32'd1;
            end
          end
          ST_DWELL: begin
            if (cnt_r == 32'd0) begin
              state_r          <= ST_CAPTURE;
              bus.res_valid    <= 1'b1;
              bus.res_chan     <= bus.meter_sel;
              bus.res_period   <= bus.meter_period;
              bus.res_duty     <= bus.meter_duty;
              bus.res_nosignal <= is_nosignal(bus.meter_period);
              bus.pass_done    <= rr_wrapped_s | rr_none_s;
              next_ch_r        <= rr_next_s;
              stop_r           <= rr_none_s | (rr_wrapped_s & bus.single_shot);
              disarm_r         <= rr_wrapped_s & bus.single_shot;
            end else begin
              cnt_r <= cnt_r - 32'd1;
            end
          end
          ST_CAPTURE: begin
            if (stop_r) begin
              state_r  <= ST_IDLE;
              bus.busy <= 1'b0;
              if (disarm_r) begin
                armed_r <= 1'b0;
              end
            end else begin
              state_r         <= ST_CLEAR;
              cnt_r           <= CLEAR_LOAD;
              bus.meter_sel   <= next_ch_r;
              bus.meter_clear <= 1'b1;
            end
          end
          default: begin
            state_r         <= ST_IDLE;
            bus.meter_clear <= 1'b0;
            bus.busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_meter_channel_scheduler.sv
// Self-checking bench for meter_channel_scheduler: directed scenarios with
// literal expectations plus a randomized run, all cross-checked every cycle
// against a time-based behavioural model.
module tb_meter_channel_scheduler;

  logic clock = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  int   cnt;
  int   t2_ch[4] = '{1, 3, 1, 3};

  meter_channel_scheduler_if bif();

  meter_channel_scheduler dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // A channel visit is tracked purely by time elapsed since its start edge:
  // clear for 2 cycles, settle 4, dwell D, then one capture cycle.
  localparam longint CLR = 2;
  localparam longint STL = 4;

  logic        m_started = 1'b0;
  logic        m_active, m_armed, m_stop, m_disarm;
  longint      m_e, m_dwell;
  int          m_next;
  logic [1:0]  exp_meter_sel, exp_res_chan;
  logic        exp_meter_clear, exp_res_valid, exp_res_nosignal, exp_busy, exp_pass_done;
  logic [31:0] exp_res_period, exp_res_duty;

  function automatic int lowest_set(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  // Rotate upward from cur; landing at or below cur means we wrapped
  function automatic int next_after(input logic [3:0] m, input int cur, output logic wr);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (cur + k) % 4;
      if (m[idx]) begin
        wr = (idx <= cur);
        return idx;
      end
    end
    wr = 1'b0;
    return -1;
  endfunction

  task automatic start_ch(input int c);
    m_active        = 1'b1;
    m_e             = 0;
    exp_meter_sel   = 2'(c);
    exp_meter_clear = 1'b1;
    exp_busy        = 1'b1;
  endtask

  always @(posedge clock) begin
    logic wr;
    m_started     = 1'b1;
    exp_res_valid = 1'b0;
    exp_pass_done = 1'b0;
    if (!reset_n) begin
      exp_meter_sel = 2'd0; exp_meter_clear = 1'b0; exp_res_chan = 2'd0;
      exp_res_period = 32'd0; exp_res_duty = 32'd0; exp_res_nosignal = 1'b0;
      exp_busy = 1'b0; m_active = 1'b0; m_armed = 1'b1; m_e = 0; m_dwell = 0;
      m_stop = 1'b0; m_disarm = 1'b0; m_next = 0;
    end else if (!bif.enable) begin
      m_armed = 1'b1; m_active = 1'b0; exp_meter_clear = 1'b0; exp_busy = 1'b0;
    end else if (!m_active) begin
      if (m_armed && bif.chan_mask != 4'd0) start_ch(lowest_set(bif.chan_mask));
    end else begin
      m_e = m_e + 1;
      if (m_e == CLR + STL)
        m_dwell = (bif.dwell_cycles < 32'd16) ? 16 : longint'(bif.dwell_cycles);
      exp_meter_clear = (m_e < CLR);
      if (m_e == CLR + STL + m_dwell) begin
        exp_res_valid    = 1'b1;
        exp_res_chan     = exp_meter_sel;
        exp_res_period   = bif.meter_period;
        exp_res_duty     = bif.meter_duty;
        exp_res_nosignal = (bif.meter_period == 32'd0) || (bif.meter_period == 32'hFFFF_FFFF);
        m_next           = next_after(bif.chan_mask, int'(exp_meter_sel), wr);
        exp_pass_done    = (m_next < 0) || wr;
        m_stop           = (m_next < 0) || (wr && bif.single_shot);
        m_disarm         = (m_next >= 0) && wr && bif.single_shot;
      end else if (m_e == CLR + STL + m_dwell + 1) begin
        if (m_stop) begin
          m_active = 1'b0;
          exp_busy = 1'b0;
          if (m_disarm) m_armed = 1'b0;
        end else begin
          start_ch(m_next);
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [72:0] dut_vec();
    return {bif.meter_sel, bif.meter_clear, bif.res_valid, bif.res_chan, bif.res_period,
            bif.res_duty, bif.res_nosignal, bif.busy, bif.pass_done};
  endfunction

  function automatic logic [72:0] exp_vec();
    return {exp_meter_sel, exp_meter_clear, exp_res_valid, exp_res_chan, exp_res_period,
            exp_res_duty, exp_res_nosignal, exp_busy, exp_pass_done};
  endfunction

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (m_started) chk("cycle_model", dut_vec(), exp_vec());
  end

  // Count negedges until res_valid is seen, bounded by budget
  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!bif.res_valid && cycles < budget);
  endtask

  task automatic idle_gap();
    bif.enable = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic count_valid(input int len, output int hits);
    hits = 0;
    repeat (len) begin
      @(negedge clock);
      if (bif.res_valid) hits++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    reset_n = 1'b0;
    bif.enable = 1'b0; bif.single_shot = 1'b0; bif.chan_mask = 4'd0;
    bif.dwell_cycles = 32'd16; bif.meter_period = 32'd0; bif.meter_duty = 32'd0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", dut_vec(), 73'd0);
    reset_n = 1'b1;

    // 1: single channel, latency 1+2+4+100
    bif.chan_mask = 4'b0001; bif.dwell_cycles = 32'd100;
    bif.meter_period = 32'd1000; bif.meter_duty = 32'd250; bif.enable = 1'b1;
    wait_valid(300, n);
    chk("t1_latency", 73'(n), 73'd107);
    chk("t1_chan", 73'(bif.res_chan), 73'd0);
    chk("t1_period", 73'(bif.res_period), 73'd1000);
    chk("t1_pass_done", 73'(bif.pass_done), 73'd1);

    // 2: continuous round robin over channels 1 and 3
    idle_gap();
    bif.chan_mask = 4'b1010; bif.dwell_cycles = 32'd16; bif.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(100, n);
      chk("t2_chan", 73'(bif.res_chan), 73'(t2_ch[i]));
      chk("t2_pass_done", 73'(bif.pass_done), 73'(i % 2));
    end

    // 3: dwell clamp and dwell change ignored while dwelling
    idle_gap();
    bif.chan_mask = 4'b0001; bif.dwell_cycles = 32'd5; bif.enable = 1'b1;
    wait_valid(100, n);
    chk("t3_clamp5", 73'(n), 73'd23);
    idle_gap();
    bif.dwell_cycles = 32'd0; bif.enable = 1'b1;
    wait_valid(100, n);
    chk("t3_clamp0", 73'(n), 73'd23);
    idle_gap();
    bif.dwell_cycles = 32'd40; bif.enable = 1'b1;
    repeat (10) @(negedge clock);
    bif.dwell_cycles = 32'd16;
    wait_valid(100, n);
    chk("t3_latched", 73'(n + 10), 73'd47);

    // 4: single shot over all channels, then no restart until enable toggles
    idle_gap();
    bif.single_shot = 1'b1; bif.chan_mask = 4'b1111; bif.meter_period = 32'h1234;
    bif.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(100, n);
      chk("t4_chan", 73'(bif.res_chan), 73'(i));
      chk("t4_pass_done", 73'(bif.pass_done), 73'(i == 3));
    end
    repeat (3) @(negedge clock);
    chk("t4_busy_off", 73'(bif.busy), 73'd0);
    count_valid(60, cnt);
    chk("t4_no_restart", 73'(cnt), 73'd0);
    bif.enable = 1'b0;
    @(negedge clock);
    bif.enable = 1'b1;
    wait_valid(100, n);
    chk("t4_rearm_latency", 73'(n), 73'd23);
    chk("t4_rearm_chan", 73'(bif.res_chan), 73'd0);

    // 5: abort mid-dwell on channel 2
    idle_gap();
    bif.single_shot = 1'b0; bif.chan_mask = 4'b0100; bif.dwell_cycles = 32'd40;
    bif.enable = 1'b1;
    repeat (20) @(negedge clock);
    bif.enable = 1'b0;
    @(negedge clock);
    chk("t5_busy", 73'(bif.busy), 73'd0);
    chk("t5_clear", 73'(bif.meter_clear), 73'd0);
    chk("t5_sel_held", 73'(bif.meter_sel), 73'd2);
    count_valid(60, cnt);
    chk("t5_no_result", 73'(cnt), 73'd0);
    chk("t5_period_held", 73'(bif.res_period), 73'h1234);
    chk("t5_chan_held", 73'(bif.res_chan), 73'd0);

    // 6: no-signal flag
    bif.chan_mask = 4'b0001; bif.dwell_cycles = 32'd16; bif.meter_period = 32'd0;
    bif.enable = 1'b1;
    wait_valid(100, n);
    chk("t6_nosig_zero", 73'(bif.res_nosignal), 73'd1);
    bif.meter_period = 32'hFFFF_FFFF;
    wait_valid(100, n);
    chk("t6_nosig_ones", 73'(bif.res_nosignal), 73'd1);
    bif.meter_period = 32'd5;
    wait_valid(100, n);
    chk("t6_nosig_five", 73'(bif.res_nosignal), 73'd0);
    chk("t6_period_five", 73'(bif.res_period), 73'd5);

    // 7: reset mid-settle, then empty mask keeps the scheduler idle
    idle_gap();
    bif.enable = 1'b1;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("t7_reset_outputs", dut_vec(), 73'd0);
    reset_n = 1'b1; bif.chan_mask = 4'd0;
    repeat (30) begin
      @(negedge clock);
      chk("t7_busy_empty_mask", 73'(bif.busy), 73'd0);
    end

    // Randomized run
    bif.chan_mask = 4'($urandom_range(1, 15));
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      r = $urandom_range(0, 9);
      bif.meter_period = (r == 0) ? 32'd0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
      bif.meter_duty   = $urandom;
      if (!bif.enable) begin
        if ($urandom_range(0, 9) == 0) bif.enable = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        bif.enable = 1'b0;
      end
      if ($urandom_range(0, 149) == 0) bif.chan_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) bif.single_shot = ~bif.single_shot;
      if ($urandom_range(0, 99) == 0) bif.dwell_cycles = 32'($urandom_range(0, 40));
    end

    idle_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
